// File: rtl/div_seq_param_pkg.sv
// Shared types and constants for the parametrised sequential divider.
package div_seq_param_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FIXUP = 2'd2,
        ZERO  = 2'd3
    } state_t;

    // Quotient reported for a zero divisor is this bit replicated across the word.
    localparam logic DIV_ZERO_FILL = 1'b1;

    // Counter wide enough to hold WIDTH-1 with one spare bit.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/div_seq_param_if.sv
// Request/response bundle between the EX-stage controller and the divider.
interface div_seq_param_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             signed_op;
    logic [WIDTH-1:0] srcA;
    logic [WIDTH-1:0] srcB;
    logic             busy;
    logic             done;
    logic             divZero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, signed_op, srcA, srcB,
        input  busy, done, divZero, hi, lo
    );

    modport slave (
        input  start, signed_op, srcA, srcB,
        output busy, done, divZero, hi, lo
    );
endinterface

// File: rtl/div_seq_param_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             num_msb,
    input  logic [WIDTH-1:0] den,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);
    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;

    // One extra bit keeps the compare exact when den exceeds 2^(WIDTH-1).
    assign trial    = {rem, num_msb};
    assign diff     = trial - {1'b0, den};
    assign q_bit    = ~diff[WIDTH];
    assign rem_next = q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
endmodule

// File: rtl/div_seq_param.sv
// Multi-cycle restoring divider with start/busy/done handshake and defined divide-by-zero.
// Signed operation is only built when DIV_SIGNED_EN is defined; otherwise all ops are unsigned.
module div_seq_param
    import div_seq_param_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    div_seq_param_if.slave bus
);
    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] num_reg;
    logic [WIDTH-1:0] den_reg;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;
    logic             done_reg;
    logic             div_zero_reg;

    logic             accept;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH-1:0] quo_fix, rem_fix, zero_hi;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;

    // done_reg is high in IDLE for one cycle; a start then is treated as arriving with done.
    assign accept = (state_reg == IDLE) && bus.start && !done_reg;

`ifdef DIV_SIGNED_EN
    logic neg_a, neg_b;
    logic q_neg_reg, r_neg_reg;

    assign neg_a = bus.signed_op & bus.srcA[WIDTH-1];
    assign neg_b = bus.signed_op & bus.srcB[WIDTH-1];
    assign mag_a = neg_a ? -bus.srcA : bus.srcA;
    assign mag_b = neg_b ? -bus.srcB : bus.srcB;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_neg_reg <= 1'b0;
            r_neg_reg <= 1'b0;
        end else if (accept) begin
            q_neg_reg <= neg_a ^ neg_b;
            r_neg_reg <= neg_a;
        end
    end

    // Negating the stored magnitude again restores the raw dividend for the zero-divisor case.
    assign quo_fix = q_neg_reg ? -num_reg : num_reg;
    assign rem_fix = r_neg_reg ? -rem_reg : rem_reg;
    assign zero_hi = r_neg_reg ? -num_reg : num_reg;
`else
    logic unused_signed_op;

    assign unused_signed_op = bus.signed_op;
    assign mag_a   = bus.srcA;
    assign mag_b   = bus.srcB;
    assign quo_fix = num_reg;
    assign rem_fix = rem_reg;
    assign zero_hi = num_reg;
`endif

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem      (rem_reg),
        .num_msb  (num_reg[WIDTH-1]),
        .den      (den_reg),
        .rem_next (step_rem),
        .q_bit    (step_q)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = (bus.srcB == '0) ? ZERO : RUN;
                end
            end
            RUN: begin
                if (cnt_reg == LAST) begin
                    state_next = FIXUP;
                end
            end
            FIXUP:   state_next = IDLE;
            ZERO:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // num_reg doubles as the quotient: dividend bits leave at the top, quotient bits enter below.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg      <= '0;
            rem_reg      <= '0;
            num_reg      <= '0;
            den_reg      <= '0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            done_reg     <= 1'b0;
            div_zero_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        cnt_reg      <= '0;
                        rem_reg      <= '0;
                        num_reg      <= mag_a;
                        den_reg      <= mag_b;
                        div_zero_reg <= 1'b0;
                    end
                end
                RUN: begin
                    rem_reg <= step_rem;
                    num_reg <= {num_reg[WIDTH-2:0], step_q};
                    cnt_reg <= cnt_reg + 1'b1;
                end
                FIXUP: begin
                    lo_reg   <= quo_fix;
                    hi_reg   <= rem_fix;
                    done_reg <= 1'b1;
                end
                ZERO: begin
                    lo_reg       <= {WIDTH{DIV_ZERO_FILL}};
                    hi_reg       <= zero_hi;
                    div_zero_reg <= 1'b1;
                    done_reg     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = (state_reg != IDLE);
    assign bus.done    = done_reg;
    assign bus.divZero = div_zero_reg;
    assign bus.hi      = hi_reg;
    assign bus.lo      = lo_reg;

endmodule
